// File: rtl/dcache_pkg.sv
// Shared types and geometry for the memory-stage data cache.
// Holds the ALU->D$ request and D$->WB request structs, the cache geometry
// with its derived offset/index/tag ranges, and the miss-handling FSM states.
package dcache_pkg;

   localparam int ADDR_WIDTH          = 32;
   localparam int DATA_WIDTH          = 32;
   localparam int REG_FILE_ADDR_WIDTH = 5;
   localparam int PC_WIDTH            = 32;

   localparam int DCACHE_NUM_LINES    = 4;
   localparam int DCACHE_LINE_WIDTH   = 128;

   localparam int DCACHE_OFFSET_WIDTH = 4;
   localparam int DCACHE_INDEX_WIDTH  = $clog2(DCACHE_NUM_LINES);
   localparam int DCACHE_TAG_LSB      = DCACHE_OFFSET_WIDTH + DCACHE_INDEX_WIDTH;
   localparam int DCACHE_TAG_WIDTH    = ADDR_WIDTH - DCACHE_TAG_LSB;

   typedef enum logic {
      Byte = 1'b0,
      Word = 1'b1
   } dcache_size_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      dcache_size_t          size;
      logic                  is_store;
      logic [DATA_WIDTH-1:0] data;
   } dcache_request_t;

   typedef struct packed {
      logic                           valid;
      logic [DATA_WIDTH-1:0]          data;
      logic                           rf_write;
      logic [REG_FILE_ADDR_WIDTH-1:0] dst_reg;
      logic [PC_WIDTH-1:0]            pc;
   } wb_request_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVICT  = 2'd1,
      FILL   = 2'd2,
      REPLAY = 2'd3
   } dcache_state_t;

   function automatic logic [DCACHE_INDEX_WIDTH-1:0] get_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[DCACHE_TAG_LSB-1:DCACHE_OFFSET_WIDTH];
   endfunction

   function automatic logic [DCACHE_TAG_WIDTH-1:0] get_tag(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:DCACHE_TAG_LSB];
   endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Tag/valid/dirty/data storage for the direct-mapped data cache.
// Ports:
//   clock, reset       - clock, async active-high reset (clears valid/dirty only)
//   i_index            - line selected for read and for any write this cycle
//   o_rd_*             - combinational read of valid, dirty, tag and line
//   i_fill_*           - whole-line write: loads tag, sets valid, clears dirty
//   i_wr_*             - byte/word merge into the resident line, sets dirty
module dcache_data_array
   import dcache_pkg::*;
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DCACHE_INDEX_WIDTH-1:0] i_index,
   output logic                          o_rd_valid,
   output logic                          o_rd_dirty,
   output logic [DCACHE_TAG_WIDTH-1:0]   o_rd_tag,
   output logic [DCACHE_LINE_WIDTH-1:0]  o_rd_line,
   input  logic                          i_fill_en,
   input  logic [DCACHE_TAG_WIDTH-1:0]   i_fill_tag,
   input  logic [DCACHE_LINE_WIDTH-1:0]  i_fill_line,
   input  logic                          i_wr_en,
   input  logic [DCACHE_OFFSET_WIDTH-1:0] i_wr_offset,
   input  dcache_size_t                  i_wr_size,
   input  logic [DATA_WIDTH-1:0]         i_wr_data
);

   logic [DCACHE_NUM_LINES-1:0]  r_valid;
   logic [DCACHE_NUM_LINES-1:0]  r_dirty;
   logic [DCACHE_TAG_WIDTH-1:0]  r_tag  [DCACHE_NUM_LINES];
   logic [DCACHE_LINE_WIDTH-1:0] r_data [DCACHE_NUM_LINES];
   logic [DCACHE_LINE_WIDTH-1:0] w_merged;

   assign o_rd_valid = r_valid[i_index];
   assign o_rd_dirty = r_dirty[i_index];
   assign o_rd_tag   = r_tag[i_index];
   assign o_rd_line  = r_data[i_index];

   // Word lanes ignore the two low offset bits.
   always_comb begin
      w_merged = r_data[i_index];
      if (i_wr_size == Word) begin
         w_merged[{i_wr_offset[3:2], 5'b0} +: 32] = i_wr_data;
      end else begin
         w_merged[{i_wr_offset, 3'b0} +: 8] = i_wr_data[7:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_en) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= 1'b0;
      end else if (i_wr_en) begin
         r_dirty[i_index] <= 1'b1;
      end
   end

   // Payload storage has no reset; valid bits gate every use of it.
   always_ff @(posedge clock) begin
      if (i_fill_en) begin
         r_tag[i_index]  <= i_fill_tag;
         r_data[i_index] <= i_fill_line;
      end else if (i_wr_en) begin
         r_data[i_index] <= w_merged;
      end
   end

endmodule

// File: rtl/dcache_top.sv
// Memory stage: direct-mapped write-back, write-allocate data cache between
// the ALU and WB stages, with a single-outstanding line-based memory port.
// Ports:
//   clock, reset             - clock, async active-high reset
//   req_*                    - request from the ALU (accepted only in IDLE)
//   dcache_busy              - stall to the ALU while a miss is handled
//   req_wb_*                 - registered request to WB
//   cache_data_bypass/_bp_valid - WB result forwarded to the ALU
//   mem_req_* / mem_rsp_*    - line write-back / fill port to memory
//
//   state  | meaning
//   IDLE   | accept requests; hits and non-M requests complete next cycle
//   EVICT  | write dirty victim line back, wait for its response
//   FILL   | fetch the requested line, install it clean
//   REPLAY | redo the latched access as a hit, then return to IDLE
module dcache_top
   import dcache_pkg::*;
(
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           req_dcache_valid,
   input  dcache_request_t                req_dcache_info,
   input  logic                           req_m_type_instr,
   input  logic                           req_r_type_instr,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] req_dst_reg,
   input  logic [PC_WIDTH-1:0]            req_dcache_pc,
   output logic                           dcache_busy,
   output logic                           req_wb_valid,
   output logic [DATA_WIDTH-1:0]          req_wb_data,
   output logic                           req_wb_rf_write,
   output logic [REG_FILE_ADDR_WIDTH-1:0] req_wb_dst_reg,
   output logic [PC_WIDTH-1:0]            req_wb_pc,
   output logic [DATA_WIDTH-1:0]          cache_data_bypass,
   output logic                           cache_data_bp_valid,
   output logic                           mem_req_valid,
   input  logic                           mem_req_ready,
   output logic                           mem_req_is_store,
   output logic [ADDR_WIDTH-1:0]          mem_req_addr,
   output logic [DCACHE_LINE_WIDTH-1:0]   mem_req_data,
   input  logic                           mem_rsp_valid,
   input  logic [DCACHE_LINE_WIDTH-1:0]   mem_rsp_data
);

   dcache_state_t                  r_state;
   dcache_state_t                  w_state_nxt;
   logic                           r_req_sent;
   logic                           w_req_sent_nxt;

   dcache_request_t                r_req_info;
   logic                           r_req_m;
   logic                           r_req_r_type;
   logic [REG_FILE_ADDR_WIDTH-1:0] r_req_dst;
   logic [PC_WIDTH-1:0]            r_req_pc;

   wb_request_t                    r_wb;

   dcache_request_t                w_acc_info;
   logic                           w_acc_m;
   logic                           w_acc_r_type;
   logic [REG_FILE_ADDR_WIDTH-1:0] w_acc_dst;
   logic [PC_WIDTH-1:0]            w_acc_pc;
   logic [DCACHE_INDEX_WIDTH-1:0]  w_index;
   logic [DCACHE_TAG_WIDTH-1:0]    w_acc_tag;

   logic                           w_rd_valid;
   logic                           w_rd_dirty;
   logic [DCACHE_TAG_WIDTH-1:0]    w_rd_tag;
   logic [DCACHE_LINE_WIDTH-1:0]   w_rd_line;
   logic                           w_hit;
   logic [DATA_WIDTH-1:0]          w_load_data;

   logic                           w_latch;
   logic                           w_wb_set;
   logic                           w_fill_en;
   logic                           w_wr_en;

   // In IDLE the live request drives the array; otherwise the latched one,
   // since the ALU drops valid while stalled.
   always_comb begin
      if (r_state == IDLE) begin
         w_acc_info   = req_dcache_info;
         w_acc_m      = req_m_type_instr;
         w_acc_r_type = req_r_type_instr;
         w_acc_dst    = req_dst_reg;
         w_acc_pc     = req_dcache_pc;
      end else begin
         w_acc_info   = r_req_info;
         w_acc_m      = r_req_m;
         w_acc_r_type = r_req_r_type;
         w_acc_dst    = r_req_dst;
         w_acc_pc     = r_req_pc;
      end
   end

   assign w_index   = get_index(w_acc_info.addr);
   assign w_acc_tag = get_tag(w_acc_info.addr);

   dcache_data_array u_data_array (
      .clock       (clock),
      .reset       (reset),
      .i_index     (w_index),
      .o_rd_valid  (w_rd_valid),
      .o_rd_dirty  (w_rd_dirty),
      .o_rd_tag    (w_rd_tag),
      .o_rd_line   (w_rd_line),
      .i_fill_en   (w_fill_en),
      .i_fill_tag  (w_acc_tag),
      .i_fill_line (mem_rsp_data),
      .i_wr_en     (w_wr_en),
      .i_wr_offset (w_acc_info.addr[DCACHE_OFFSET_WIDTH-1:0]),
      .i_wr_size   (w_acc_info.size),
      .i_wr_data   (w_acc_info.data)
   );

   assign w_hit = w_rd_valid && (w_rd_tag == w_acc_tag);

   always_comb begin
      w_load_data = '0;
      if (w_acc_info.size == Word) begin
         w_load_data = w_rd_line[{w_acc_info.addr[3:2], 5'b0} +: 32];
      end else begin
         w_load_data[7:0] = w_rd_line[{w_acc_info.addr[3:0], 3'b0} +: 8];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_req_sent <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_req_sent <= w_req_sent_nxt;
      end
   end

   // r_req_sent marks a handshake already taken in EVICT/FILL; the
   // response is only honoured once it is set.
   always_comb begin
      w_state_nxt      = r_state;
      w_req_sent_nxt   = r_req_sent;
      dcache_busy      = 1'b0;
      mem_req_valid    = 1'b0;
      mem_req_is_store = 1'b0;
      mem_req_addr     = '0;
      mem_req_data     = '0;
      w_latch          = 1'b0;
      w_wb_set         = 1'b0;
      w_fill_en        = 1'b0;
      w_wr_en          = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_dcache_valid) begin
               w_latch = 1'b1;
               if (!req_m_type_instr || w_hit) begin
                  w_wb_set = 1'b1;
                  w_wr_en  = req_m_type_instr && req_dcache_info.is_store;
               end else begin
                  dcache_busy = 1'b1;
                  w_state_nxt = (w_rd_valid && w_rd_dirty) ? EVICT : FILL;
               end
            end
         end
         EVICT: begin
            dcache_busy = 1'b1;
            if (!r_req_sent) begin
               mem_req_valid    = 1'b1;
               mem_req_is_store = 1'b1;
               mem_req_addr     = {w_rd_tag, w_index, {DCACHE_OFFSET_WIDTH{1'b0}}};
               mem_req_data     = w_rd_line;
               if (mem_req_ready) begin
                  w_req_sent_nxt = 1'b1;
               end
            end else if (mem_rsp_valid) begin
               w_req_sent_nxt = 1'b0;
               w_state_nxt    = FILL;
            end
         end
         FILL: begin
            dcache_busy = 1'b1;
            if (!r_req_sent) begin
               mem_req_valid = 1'b1;
               mem_req_addr  = {w_acc_tag, w_index, {DCACHE_OFFSET_WIDTH{1'b0}}};
               if (mem_req_ready) begin
                  w_req_sent_nxt = 1'b1;
               end
            end else if (mem_rsp_valid) begin
               w_fill_en      = 1'b1;
               w_req_sent_nxt = 1'b0;
               w_state_nxt    = REPLAY;
            end
         end
         REPLAY: begin
            dcache_busy = 1'b1;
            w_wb_set    = 1'b1;
            w_wr_en     = r_req_info.is_store;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt    = IDLE;
            w_req_sent_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_req_info   <= '0;
         r_req_m      <= 1'b0;
         r_req_r_type <= 1'b0;
         r_req_dst    <= '0;
         r_req_pc     <= '0;
      end else if (w_latch) begin
         r_req_info   <= req_dcache_info;
         r_req_m      <= req_m_type_instr;
         r_req_r_type <= req_r_type_instr;
         r_req_dst    <= req_dst_reg;
         r_req_pc     <= req_dcache_pc;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wb <= '0;
      end else begin
         r_wb.valid <= w_wb_set;
         if (w_wb_set) begin
            if (w_acc_m) begin
               r_wb.data     <= w_acc_info.is_store ? '0 : w_load_data;
               r_wb.rf_write <= !w_acc_info.is_store;
            end else begin
               r_wb.data     <= w_acc_info.data;
               r_wb.rf_write <= w_acc_r_type;
            end
            r_wb.dst_reg <= w_acc_dst;
            r_wb.pc      <= w_acc_pc;
         end
      end
   end

   assign req_wb_valid        = r_wb.valid;
   assign req_wb_data         = r_wb.data;
   assign req_wb_rf_write     = r_wb.rf_write;
   assign req_wb_dst_reg      = r_wb.dst_reg;
   assign req_wb_pc           = r_wb.pc;
   assign cache_data_bypass   = r_wb.data;
   assign cache_data_bp_valid = r_wb.valid & r_wb.rf_write;

endmodule

// File: doc/dcache_top.md
Name: dcache_top

Overview:
- Memory stage directly downstream of the ALU stage. Receives the ALU's D$ request and produces the write-back (WB) request.
- M-type instructions access a direct-mapped, write-back, write-allocate data cache. Misses are served through a single-outstanding memory port.
- Non-memory instructions are flopped through unchanged.
- Provides the cache-to-ALU bypass, and asserts dcache_busy to stall the ALU during miss handling.

Parameters:
- DCACHE_NUM_LINES, 4, number of cache lines (power of 2).
- DCACHE_LINE_WIDTH, 128, line size in bits.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, register/word width (equals REG_FILE_DATA_WIDTH).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_dcache_valid  in  1  request from ALU
- req_dcache_info  in  dcache_request_t  addr/size/is_store/data
- req_m_type_instr  in  1  request accesses memory
- req_r_type_instr  in  1  request writes RF with ALU result
- req_dst_reg  in  REG_FILE_ADDR_WIDTH  destination register
- req_dcache_pc  in  PC_WIDTH  instruction PC
- dcache_busy  out  1  stall to ALU (drives stall_alu)
- req_wb_valid  out  1  request to WB
- req_wb_data  out  DATA_WIDTH  result data
- req_wb_rf_write  out  1  WB must write RF
- req_wb_dst_reg  out  REG_FILE_ADDR_WIDTH  destination register
- req_wb_pc  out  PC_WIDTH  PC to retire
- cache_data_bypass  out  DATA_WIDTH  equals req_wb_data
- cache_data_bp_valid  out  1  req_wb_valid & req_wb_rf_write
- mem_req_valid  out  1  memory request; held until mem_req_ready
- mem_req_ready  in  1  memory accepts request
- mem_req_is_store  out  1  1 = line write-back, 0 = line fill
- mem_req_addr  out  ADDR_WIDTH  line-aligned address
- mem_req_data  out  DCACHE_LINE_WIDTH  evicted line
- mem_rsp_valid  in  1  memory response; one per accepted request
- mem_rsp_data  in  DCACHE_LINE_WIDTH  fill data (ignored for stores)

Behaviour:
- Reset values:
  - All outputs 0.
  - Valid and dirty bits of every line cleared.
  - FSM in IDLE.
- Address split: offset = addr[3:0], index = addr[3+log2(LINES):4], tag = remaining upper bits.
- Alignment:
  - Word accesses ignore addr[1:0] and use word addr[3:2].
  - Byte accesses use addr[3:0].
- Loads:
  - Word loads return the selected word.
  - Byte loads return the selected byte zero-extended to 32 bits.
- Stores:
  - Merge the data into the line (byte or word lane) and set the dirty bit.
  - A store sets req_wb_rf_write=0.
- Non-M requests:
  - Registered pass-through with 1-cycle latency; data = req_dcache_info.data.
  - rf_write = req_r_type_instr.
  - No array access.
- Hit: an M request accepted in IDLE at cycle T is a hit when the line is valid and the tag matches. req_wb_valid is asserted at T+1 for exactly one cycle.
- Acceptance rules:
  - A request is accepted only in IDLE.
  - The full request (info, flags, dst, pc) is latched on acceptance, because the ALU drops valid while stalled.
  - req_dcache_valid is ignored outside IDLE.
- dcache_busy:
  - Asserted combinationally in the miss-detect cycle.
  - Stays asserted in every non-IDLE state.
  - Deasserted in the cycle req_wb_valid rises for the replayed request.
- FSM states:
  - IDLE → EVICT on a miss where the victim is valid and dirty.
  - IDLE → FILL on a miss where the victim is clean or invalid.
  - EVICT: mem_req_valid=1, is_store=1, address = {victim tag, index, 0}, data = victim line. Wait for handshake, then wait for mem_rsp_valid, then go to FILL.
  - FILL: mem_req_valid=1, is_store=0, address = line-aligned request address. On handshake, drop valid. On mem_rsp_valid, write the line, set tag and valid, clear dirty, go to REPLAY.
  - REPLAY: perform the latched access as a hit (store merges and sets dirty). Drive the WB outputs next cycle and go to IDLE.
- Memory port:
  - mem_req_* stay stable while mem_req_valid=1 and mem_req_ready=0.
  - mem_rsp_valid may arrive no earlier than one cycle after the handshake.
  - An mem_rsp_valid in IDLE or REPLAY is ignored.
- Reset mid-miss: return to IDLE, drop mem_req_valid, clear all valid bits. Any later stray response is ignored.
- req_wb_valid is never asserted on consecutive cycles for the same request.

Decomposition:
- Shared package (soc.vh):
  - dcache_request_t, with the size enum {Byte, Word}.
  - The new wb_request_t.
  - DCACHE_NUM_LINES, DCACHE_LINE_WIDTH and derived index/tag/offset ranges.
  - dcache_state_t {IDLE, EVICT, FILL, REPLAY}.
  - RST_FF / EN_FF macros.
- One sub-module, dcache_data_array:
  - Tag/valid/dirty/data storage with async-reset valid/dirty bits.
  - Combinational read; synchronous line write and byte/word merge write.
- FSM, request latch and WB register remain in dcache_top.

Test Plan:
- Non-M pass-through: ADD result 0x0000_0005, dst r3, r_type=1 → next cycle req_wb_valid=1, data=5, rf_write=1, bp_valid=1; no mem_req.
- Cold load: LDW 0x0000_0104 → EVICT skipped; mem_req addr=0x100, is_store=0; rsp line word1=0xDEAD_BEEF → busy deasserts with req_wb_data=0xDEADBEEF.
- Store then load hits:
  - STB data 0xAB to 0x105 (line present) → no mem_req, rf_write=0.
  - LDB 0x105 → data 0x0000_00AB; LDW 0x104 → 0xDEAD_ABEF.
- Dirty eviction: with 4 lines, LDW 0x144 after the dirty 0x100 line → mem_req is_store=1 addr=0x100 carrying the dirty data, then fill addr=0x140; result correct; new line clean.
- Backpressure: hold mem_req_ready=0 for 5 cycles in FILL → mem_req_* stable, busy=1, req_dcache_valid pulses ignored.
- Reset mid-FILL: assert reset after the handshake, then deliver mem_rsp_valid → all outputs 0, response ignored; next LDW 0x100 misses again.
